// File: rtl/sudoku_board_loader.sv
// Assembles BCD cell digits into the solver's packed board; state, board, cursor, givens and error update one cycle after the event.
// digit_ready_out is low while FULL, in reset, or under clear/backspace; a full board is held until board_ack_in.
module sudoku_board_loader #(
   parameter int GRID_SIZE = 9
) (
   input  logic                                 clk_in,
   input  logic                                 reset_in,
   input  logic [3:0]                           digit_in,
   input  logic                                 digit_valid_in,
   output logic                                 digit_ready_out,
   input  logic                                 backspace_in,
   input  logic                                 clear_in,
   input  logic                                 board_ack_in,
   output logic [4*GRID_SIZE*GRID_SIZE-1:0]     board_out,
   output logic                                 board_valid_out,
   output logic [6:0]                           cell_index_out,
   output logic [6:0]                           givens_out,
   output logic                                 error_out
);
   localparam int         CELLS = GRID_SIZE * GRID_SIZE;
   localparam logic [6:0] LAST  = 7'(CELLS - 1);

   typedef enum logic {LOAD, FULL} state_t;

   state_t                state_q, state_d;
   logic [CELLS-1:0][3:0] board_q, board_d;
   logic [6:0]            idx_q, idx_d;
   logic [6:0]            givens_q, givens_d;
   logic                  err_q, err_d;
   logic                  accept;
   logic                  wr_en;
   logic [6:0]            wr_idx;
   logic [3:0]            wr_val;
   logic [3:0]            old_val;

   assign digit_ready_out = (state_q == LOAD) && !reset_in && !clear_in && !backspace_in;
   assign accept          = digit_valid_in && digit_ready_out;

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state_q  <= LOAD;
         board_q  <= '0;
         idx_q    <= '0;
         givens_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         board_q  <= board_d;
         idx_q    <= idx_d;
         givens_q <= givens_d;
         err_q    <= err_d;
      end
   end

   // At most one cell is written per cycle; clear is the only bulk update.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      err_d    = 1'b0;
      wr_en    = 1'b0;
      wr_idx   = idx_q;
      wr_val   = 4'd0;
      board_d  = board_q;
      givens_d = givens_q;
      old_val  = 4'd0;

      if (clear_in) begin
         state_d = LOAD;
         idx_d   = '0;
      end else if (backspace_in) begin
         if (state_q == FULL) begin
            wr_en   = 1'b1;
            state_d = LOAD;
         end else if (idx_q != 7'd0) begin
            wr_en  = 1'b1;
            wr_idx = idx_q - 7'd1;
            idx_d  = idx_q - 7'd1;
         end
      end else if (accept) begin
         if (digit_in > 4'd9) begin
            err_d = 1'b1;
         end else begin
            wr_en  = 1'b1;
            wr_val = digit_in;
            if (idx_q == LAST) state_d = FULL;
            else               idx_d   = idx_q + 7'd1;
         end
      end else if (board_ack_in && (state_q == FULL)) begin
         state_d = LOAD;
         idx_d   = '0;
      end

      if (clear_in) begin
         board_d  = '0;
         givens_d = '0;
      end else if (wr_en) begin
         old_val         = board_q[wr_idx];
         board_d[wr_idx] = wr_val;
         if ((old_val == 4'd0) && (wr_val != 4'd0))      givens_d = givens_q + 7'd1;
         else if ((old_val != 4'd0) && (wr_val == 4'd0)) givens_d = givens_q - 7'd1;
      end
   end

   assign board_out       = board_q;
   assign board_valid_out = (state_q == FULL);
   assign cell_index_out  = idx_q;
   assign givens_out      = givens_q;
   assign error_out       = err_q;
endmodule
